// File: rtl/project_cfg_pkg.sv
// Shared board constants: cell status encoding, operation codes and board sizes.
package project_cfg_pkg;

  localparam logic [1:0] GRID_STATUS_EMPTY  = 2'b00;
  localparam logic [1:0] GRID_STATUS_MYSHIP = 2'b01;
  localparam logic [1:0] GRID_STATUS_MISS   = 2'b10;
  localparam logic [1:0] GRID_STATUS_HIT    = 2'b11;

  localparam int GRID_CELLS = 100;
  localparam int SHIP_CELLS = 20;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SHOT  = 2'd2
  } grid_op_t;

  // Cell status after a shot lands on a cell holding `old`.
  function automatic logic [1:0] shot_result(input logic [1:0] old);
    case (old)
      GRID_STATUS_MYSHIP: shot_result = GRID_STATUS_HIT;
      GRID_STATUS_EMPTY:  shot_result = GRID_STATUS_MISS;
      default:            shot_result = old;
    endcase
  endfunction

endpackage

// File: rtl/grid_ram.sv
// Board storage: 2-bit cells, sync read/write port A and independent sync read port B.
module grid_ram #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [1:0]        a_wdata_i,
  output logic [1:0]        a_rdata_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  output logic [1:0]        b_rdata_o
);

  logic [1:0] mem_q [2**ADDR_W];

  // Read-first on port A; port B also sees the pre-write value in a colliding cycle.
  always_ff @(posedge clk) begin
    if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
    a_rdata_o <= mem_q[a_addr_i];
  end

  always_ff @(posedge clk) begin
    b_rdata_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/grid_mem_arbiter.sv
// Round-robin shared board memory with clear sweep, read/write/shot sequencing and a display port.
// Optional hit counter and all_sunk flag built when GRID_HIT_COUNT_EN is defined.
module grid_mem_arbiter
  import project_cfg_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int GRID_DIM = 10,
  parameter int ADDR_W   = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_req,
  output logic                    clear_busy,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*2-1:0]      op,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*2-1:0]      wdata,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic [1:0]              rdata,
  input  logic [ADDR_W-1:0]       disp_addr,
  output logic [1:0]              disp_data,
  output logic                    all_sunk
);

  localparam int CELLS = GRID_DIM * GRID_DIM;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RD, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pend_q, pend_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        win_q, win_d;
  grid_op_t          op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        wdata_q, wdata_d;
  logic              oor_q, oor_d;
  logic [1:0]        rdata_q, rdata_d;
  logic              disp_ok_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_wdata;
  logic [1:0]        ram_rdata;
  logic [1:0]        ram_disp;

  logic [1:0]        win;
  logic              any_req;
  logic [ADDR_W-1:0] sel_addr;

  grid_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .a_we_i    (ram_we),
    .a_addr_i  (ram_addr),
    .a_wdata_i (ram_wdata),
    .a_rdata_o (ram_rdata),
    .b_addr_i  (disp_addr),
    .b_rdata_o (ram_disp)
  );

  // First requester at or after the round-robin pointer.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_req && req[(int'(rr_q) + k) % N_REQ]) begin
        any_req = 1'b1;
        win     = 2'((int'(rr_q) + k) % N_REQ);
      end
    end
  end

  assign sel_addr = addr[int'(win)*ADDR_W +: ADDR_W];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    rr_d      = rr_q;
    win_d     = win_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    oor_d     = oor_q;
    rdata_d   = rdata_q;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    case (state_q)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = idx_q;
        ram_wdata = GRID_STATUS_EMPTY;
        pend_d    = 1'b0;
        if (idx_q == ADDR_W'(CELLS - 1)) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (pend_q || clear_req) begin
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = S_CLEAR;
        end else if (any_req) begin
          win_d   = win;
          op_d    = grid_op_t'(op[int'(win)*2 +: 2]);
          addr_d  = sel_addr;
          wdata_d = wdata[int'(win)*2 +: 2];
          oor_d   = ({1'b0, sel_addr} >= (ADDR_W+1)'(CELLS));
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (clear_req) pend_d = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        if (clear_req) pend_d = 1'b1;
        rdata_d = oor_q ? GRID_STATUS_EMPTY : ram_rdata;
        if (!oor_q) begin
          case (op_q)
            OP_WRITE: ram_we = 1'b1;
            OP_SHOT: begin
              ram_wdata = shot_result(ram_rdata);
              ram_we    = (ram_rdata == GRID_STATUS_MYSHIP) || (ram_rdata == GRID_STATUS_EMPTY);
            end
            default: ram_we = 1'b0;
          endcase
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (clear_req) pend_d = 1'b1;
        rr_d    = 2'((int'(win_q) + 1) % N_REQ);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      rr_q      <= '0;
      win_q     <= '0;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      oor_q     <= 1'b0;
      rdata_q   <= GRID_STATUS_EMPTY;
      disp_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      oor_q     <= oor_d;
      rdata_q   <= rdata_d;
      disp_ok_q <= ({1'b0, disp_addr} < (ADDR_W+1)'(CELLS));
    end
  end

  assign clear_busy = (state_q == S_CLEAR);
  assign ack        = (state_q == S_DONE) ? (N_REQ'(1) << win_q) : '0;
  assign err        = (state_q == S_DONE) && oor_q;
  assign rdata      = rdata_q;
  // Cells beyond the board are never cleared, so mask them out rather than expose stale RAM.
  assign disp_data  = disp_ok_q ? ram_disp : GRID_STATUS_EMPTY;

`ifdef GRID_HIT_COUNT_EN
  logic [6:0] hit_cnt_q;
  logic       all_sunk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      all_sunk_q <= 1'b0;
    end else begin
      if (state_q == S_CLEAR) begin
        hit_cnt_q <= '0;
      end else if (state_q == S_WR && !oor_q && op_q == OP_SHOT &&
                   ram_rdata == GRID_STATUS_MYSHIP) begin
        hit_cnt_q <= hit_cnt_q + 1'b1;
      end
      all_sunk_q <= (hit_cnt_q == 7'(SHIP_CELLS));
    end
  end

  assign all_sunk = all_sunk_q;
`else
  assign all_sunk = 1'b0;
`endif

endmodule
